// File: rtl/abc_input_conditioner.sv
// Three-channel synchronise + debounce front end for the LED detector.
// Optional rise/fall edge buses are enabled with macro ABC_COND_EDGE_EN.
module abc_cond_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic commit,
  output logic idle
);
  typedef enum logic {STABLE, PENDING} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   level_nxt, s;
  state_t                 state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  assign s = sync[SYNC_STAGES-1];

  // Stable vs pending is implied by the synchronised level disagreeing with the output.
  always_comb begin
    state     = (s != level) ? PENDING : STABLE;
    cnt_nxt   = '0;
    level_nxt = level;
    commit    = 1'b0;
    case (state)
      STABLE: cnt_nxt = '0;
      PENDING: begin
        if (cnt == CNT_MAX) begin
          commit    = 1'b1;
          level_nxt = s;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: cnt_nxt = '0;
    endcase
    idle = (state == STABLE) && (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      level <= level_nxt;
    end
  end
endmodule

module abc_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic       raw_c,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       settled,
`ifdef ABC_COND_EDGE_EN
  output logic [2:0] rise,
  output logic [2:0] fall,
`endif
  output logic       changed
);
  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0] raw, lvl, commit, idle, last;

  assign raw = {raw_a, raw_b, raw_c};
  assign {A, B, C} = lvl;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    abc_cond_lane #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)
    ) u_lane (
      .clk(clk), .rst(rst), .raw(raw[i]),
      .level(lvl[i]), .commit(commit[i]), .idle(idle[i])
    );
  end

  // Status pulses trail the level update by one cycle: compare against last cycle's levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= '0;
      changed <= 1'b0;
      settled <= 1'b1;
    end else begin
      last    <= lvl;
      changed <= |(lvl ^ last);
      settled <= &idle;
    end
  end

`ifdef ABC_COND_EDGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= lvl & ~last;
      fall <= ~lvl & last;
    end
  end
`endif

  logic unused;
  assign unused = ^commit;
endmodule
